// File: rtl/rv_alu_pipeline.sv
// rv_alu_pipeline: five-stage in-order RV32I/RV64I register-immediate ALU
// pipeline (IF/ID/EX/MEM/WB) with LUI, selectable bypass or interlock,
// illegal-instruction flagging and a registered retire trace port.
// MEM is a pass-through stage held for the future load/store unit.
module rv_alu_pipeline #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter int unsigned     FORWARD  = 1,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_insn,
  input  logic            imem_valid,
  output logic            retire_valid,
  output logic [XLEN-1:0] retire_pc,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  output logic [15:0]     stall_count
);

  localparam int RW  = $clog2(NREG);
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  typedef enum logic [3:0] {
    OP_ADD, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_LUI
  } alu_op_e;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_insn_q, ifid_insn_d;
  logic            idex_valid_q, idex_valid_d, idex_illegal_q, idex_illegal_d;
  logic            idex_uses_q, idex_uses_d;
  logic [XLEN-1:0] idex_pc_q, idex_pc_d, idex_a_q, idex_a_d, idex_imm_q, idex_imm_d;
  logic [4:0]      idex_rd_q, idex_rd_d, idex_rs1_q, idex_rs1_d;
  alu_op_e         idex_op_q, idex_op_d;
  logic            exmem_valid_q, exmem_valid_d, exmem_illegal_q, exmem_illegal_d;
  logic [XLEN-1:0] exmem_pc_q, exmem_pc_d, exmem_data_q, exmem_data_d;
  logic [4:0]      exmem_rd_q, exmem_rd_d;
  logic            wb_valid_q, wb_valid_d, wb_illegal_q, wb_illegal_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d, wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [15:0]     stall_count_q, stall_count_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd_f, rs1_f;
  logic            dec_legal, dec_uses, shift_hi_zero, shift_hi_sra;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_imm, rs1_val;
  logic            rf_wr_en, stall;
  logic [XLEN-1:0] ex_a, ex_result;
  logic [SHW-1:0]  shamt;

  assign opcode = ifid_insn_q[6:0];
  assign funct3 = ifid_insn_q[14:12];
  assign rd_f   = ifid_insn_q[11:7];
  assign rs1_f  = ifid_insn_q[19:15];

  // Decode the ID instruction into an ALU op, legality flag and immediate
  always_comb begin
    dec_legal     = 1'b0;
    dec_uses      = 1'b0;
    dec_op        = OP_ADD;
    dec_imm       = XLEN'($signed(ifid_insn_q[31:20]));
    shift_hi_zero = (XLEN == 64) ? (ifid_insn_q[31:26] == 6'b000000)
                                 : (ifid_insn_q[31:25] == 7'b0000000);
    shift_hi_sra  = (XLEN == 64) ? (ifid_insn_q[31:26] == 6'b010000)
                                 : (ifid_insn_q[31:25] == 7'b0100000);
    case (opcode)
      7'b0110111: begin
        dec_legal = 1'b1;
        dec_op    = OP_LUI;
        dec_imm   = XLEN'($signed({ifid_insn_q[31:12], 12'h000}));
      end
      7'b0010011: begin
        dec_uses  = 1'b1;
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b110:  dec_op = OP_OR;
          3'b111:  dec_op = OP_AND;
          3'b001: begin
            dec_op    = OP_SLL;
            dec_legal = shift_hi_zero;
          end
          default: begin
            dec_op    = shift_hi_sra ? OP_SRA : OP_SRL;
            dec_legal = shift_hi_zero | shift_hi_sra;
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    if ((32'(rd_f) >= NREG) || (dec_uses && (32'(rs1_f) >= NREG))) dec_legal = 1'b0;
  end

  // Register-file read with write-through from the retiring instruction
  always_comb begin
    rf_wr_en = wb_valid_q && !wb_illegal_q && (wb_rd_q != 5'd0);
    if (rs1_f == 5'd0)                      rs1_val = '0;
    else if (rf_wr_en && (wb_rd_q == rs1_f)) rs1_val = wb_data_q;
    else                                     rs1_val = rf_q[rs1_f[RW-1:0]];
  end

  // Interlock: hold ID while an older in-flight instruction still owns rs1
  always_comb begin
    stall = 1'b0;
    if ((FORWARD == 0) && ifid_valid_q && dec_legal && dec_uses && (rs1_f != 5'd0)) begin
      stall = (idex_valid_q && !idex_illegal_q && (idex_rd_q == rs1_f)) ||
              (exmem_valid_q && !exmem_illegal_q && (exmem_rd_q == rs1_f));
    end
  end

  // EX operand selection (bypass, EX/MEM first) and the ALU itself
  always_comb begin
    ex_a = idex_a_q;
    if ((FORWARD != 0) && idex_uses_q) begin
      if (exmem_valid_q && !exmem_illegal_q && (exmem_rd_q != 5'd0) && (exmem_rd_q == idex_rs1_q))
        ex_a = exmem_data_q;
      else if (wb_valid_q && !wb_illegal_q && (wb_rd_q != 5'd0) && (wb_rd_q == idex_rs1_q))
        ex_a = wb_data_q;
    end
    shamt = idex_imm_q[SHW-1:0];
    case (idex_op_q)
      OP_ADD:  ex_result = ex_a + idex_imm_q;
      OP_SLT:  ex_result = XLEN'($signed(ex_a) < $signed(idex_imm_q));
      OP_SLTU: ex_result = XLEN'(ex_a < idex_imm_q);
      OP_XOR:  ex_result = ex_a ^ idex_imm_q;
      OP_OR:   ex_result = ex_a | idex_imm_q;
      OP_AND:  ex_result = ex_a & idex_imm_q;
      OP_SLL:  ex_result = ex_a << shamt;
      OP_SRL:  ex_result = ex_a >> shamt;
      OP_SRA:  ex_result = XLEN'($signed(ex_a) >>> shamt);
      default: ex_result = idex_imm_q;
    endcase
  end

  // Next-state for every pipeline stage, the stall counter and the register file
  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_insn_d  = ifid_insn_q;
    if (!stall) begin
      ifid_valid_d = imem_valid;
      ifid_pc_d    = pc_q;
      ifid_insn_d  = imem_insn;
      if (imem_valid) pc_d = pc_q + XLEN'(4);
    end

    idex_valid_d   = ifid_valid_q && !stall;
    idex_illegal_d = !dec_legal;
    idex_uses_d    = dec_uses;
    idex_pc_d      = ifid_pc_q;
    idex_rd_d      = dec_legal ? rd_f : 5'd0;
    idex_rs1_d     = rs1_f;
    idex_op_d      = dec_op;
    idex_a_d       = rs1_val;
    idex_imm_d     = dec_imm;

    exmem_valid_d   = idex_valid_q;
    exmem_illegal_d = idex_illegal_q;
    exmem_pc_d      = idex_pc_q;
    exmem_rd_d      = idex_rd_q;
    exmem_data_d    = (idex_valid_q && !idex_illegal_q) ? ex_result : '0;

    wb_valid_d   = exmem_valid_q;
    wb_illegal_d = exmem_illegal_q;
    wb_pc_d      = exmem_pc_q;
    wb_rd_d      = exmem_rd_q;
    wb_data_d    = exmem_data_q;

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;

    rf_d = rf_q;
    if (rf_wr_en) rf_d[wb_rd_q[RW-1:0]] = wb_data_q;
  end

  // State registers; reset empties the pipe and clears the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= PC_RESET;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= '0;
      ifid_insn_q     <= '0;
      idex_valid_q    <= 1'b0;
      idex_illegal_q  <= 1'b0;
      idex_uses_q     <= 1'b0;
      idex_pc_q       <= '0;
      idex_rd_q       <= '0;
      idex_rs1_q      <= '0;
      idex_op_q       <= OP_ADD;
      idex_a_q        <= '0;
      idex_imm_q      <= '0;
      exmem_valid_q   <= 1'b0;
      exmem_illegal_q <= 1'b0;
      exmem_pc_q      <= '0;
      exmem_rd_q      <= '0;
      exmem_data_q    <= '0;
      wb_valid_q      <= 1'b0;
      wb_illegal_q    <= 1'b0;
      wb_pc_q         <= '0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      stall_count_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_insn_q     <= ifid_insn_d;
      idex_valid_q    <= idex_valid_d;
      idex_illegal_q  <= idex_illegal_d;
      idex_uses_q     <= idex_uses_d;
      idex_pc_q       <= idex_pc_d;
      idex_rd_q       <= idex_rd_d;
      idex_rs1_q      <= idex_rs1_d;
      idex_op_q       <= idex_op_d;
      idex_a_q        <= idex_a_d;
      idex_imm_q      <= idex_imm_d;
      exmem_valid_q   <= exmem_valid_d;
      exmem_illegal_q <= exmem_illegal_d;
      exmem_pc_q      <= exmem_pc_d;
      exmem_rd_q      <= exmem_rd_d;
      exmem_data_q    <= exmem_data_d;
      wb_valid_q      <= wb_valid_d;
      wb_illegal_q    <= wb_illegal_d;
      wb_pc_q         <= wb_pc_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      stall_count_q   <= stall_count_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign imem_addr    = pc_q;
  assign retire_valid = wb_valid_q;
  assign retire_pc    = wb_pc_q;
  assign retire_rd    = wb_rd_q;
  assign retire_data  = wb_data_q;
  assign illegal      = wb_valid_q && wb_illegal_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_rv_alu_pipeline.sv
// tb_rv_alu_pipeline: drives a bypassing RV32I core and an interlocked RV32E
// core from one shared program memory and checks both, cycle by cycle,
// against an instruction-level reference with a stage-timing recurrence.
module tb_rv_alu_pipeline;

  localparam int MAXC = 400;
  localparam int MAXI = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] prog [MAXI];
  bit          vpat [MAXC];
  int          nins;
  int          cyc;
  logic [31:0] lim;

  logic [31:0] addr [2];
  logic [31:0] insn [2];
  logic        iv [2];
  logic        rv [2];
  logic [31:0] rpc [2];
  logic [4:0]  rrd [2];
  logic [31:0] rdata [2];
  logic        ill [2];
  logic [15:0] scnt [2];

  int total = 0;
  int bad = 0;

  int          exp_cyc [2][MAXI];
  logic [31:0] exp_pc [2][MAXI];
  logic [4:0]  exp_rd [2][MAXI];
  logic [31:0] exp_data [2][MAXI];
  logic        exp_ill [2][MAXI];
  int          pc_at [2][MAXC];
  int          stall_at [2][MAXC];
  int          last_cyc [2];
  int          ptr [2];

  assign lim = 32'(4 * nins);
  for (genvar g = 0; g < 2; g++) begin : g_imem
    assign insn[g] = prog[addr[g][7:2]];
    assign iv[g]   = vpat[cyc] && (addr[g] < lim);
  end

  rv_alu_pipeline #(.XLEN(32), .NREG(32), .FORWARD(1), .PC_RESET(32'h0)) dut_f (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr[0]), .imem_insn(insn[0]), .imem_valid(iv[0]),
    .retire_valid(rv[0]), .retire_pc(rpc[0]), .retire_rd(rrd[0]), .retire_data(rdata[0]),
    .illegal(ill[0]), .stall_count(scnt[0]));

  rv_alu_pipeline #(.XLEN(32), .NREG(16), .FORWARD(0), .PC_RESET(32'h0)) dut_i (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr[1]), .imem_insn(insn[1]), .imem_valid(iv[1]),
    .retire_valid(rv[1]), .retire_pc(rpc[1]), .retire_rd(rrd[1]), .retire_data(rdata[1]),
    .illegal(ill[1]), .stall_count(scnt[1]));

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3, input int rd);
    logic [11:0] i12;
    i12 = imm[11:0];
    return {i12, 5'(rs1), f3, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lui(input int imm20, input int rd);
    logic [19:0] u;
    u = imm20[19:0];
    return {u, 5'(rd), 7'b0110111};
  endfunction

  // Architectural meaning of one instruction given its rs1 value
  function automatic void ref_exec(input logic [31:0] in, input bit nr16, input logic [31:0] a,
                                   output bit legal, output bit uses, output logic [31:0] val);
    logic [31:0] imm;
    logic [4:0]  sh;
    logic [6:0]  hi;
    imm = {{20{in[31]}}, in[31:20]};
    sh  = in[24:20];
    hi  = in[31:25];
    legal = 1'b0;
    uses  = 1'b0;
    val   = 32'h0;
    if (in[6:0] == 7'h37) begin
      legal = 1'b1;
      val   = {in[31:12], 12'h000};
    end else if (in[6:0] == 7'h13) begin
      uses  = 1'b1;
      legal = 1'b1;
      case (in[14:12])
        3'd0: val = a + imm;
        3'd2: val = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: val = (a < imm) ? 32'd1 : 32'd0;
        3'd4: val = a ^ imm;
        3'd6: val = a | imm;
        3'd7: val = a & imm;
        3'd1: begin
          if (hi != 7'h00) legal = 1'b0;
          val = a << sh;
        end
        default: begin
          if (hi == 7'h00)      val = a >> sh;
          else if (hi == 7'h20) val = $signed(a) >>> sh;
          else                  legal = 1'b0;
        end
      endcase
    end
    if (nr16 && ((in[11:7] >= 5'd16) || (uses && (in[19:15] >= 5'd16)))) legal = 1'b0;
    if (!legal) val = 32'h0;
  endfunction

  // Expected retire stream and per-cycle PC / stall count for one core
  task automatic buildModel(input int c);
    logic [31:0] regs [32];
    int dd [MAXI];
    int wrd [MAXI];
    int freec, fc, d, rs1, rd;
    bit legal, uses;
    logic [31:0] val;
    for (int r = 0; r < 32; r++) regs[r] = 32'h0;
    for (int cc = 0; cc < MAXC; cc++) begin
      pc_at[c][cc]    = 0;
      stall_at[c][cc] = 0;
    end
    freec = 0;
    for (int k = 0; k < nins; k++) begin
      rs1 = int'(prog[k][19:15]);
      rd  = int'(prog[k][11:7]);
      ref_exec(prog[k], (c == 1), regs[rs1], legal, uses, val);
      fc = freec;
      while (fc < MAXC - 1 && !vpat[fc]) fc++;
      d = fc + 1;
      if (c == 1 && legal && uses && rs1 != 0)
        for (int j = 0; j < k; j++)
          if (wrd[j] == rs1 && dd[j] + 3 > d) d = dd[j] + 3;
      dd[k]  = d;
      wrd[k] = legal ? rd : 0;
      freec  = d;
      exp_cyc[c][k]  = d + 3;
      exp_pc[c][k]   = 32'(4 * k);
      exp_rd[c][k]   = legal ? 5'(rd) : 5'd0;
      exp_data[c][k] = val;
      exp_ill[c][k]  = !legal;
      if (legal && rd != 0) regs[rd] = val;
      for (int cc = fc + 1; cc < MAXC; cc++) pc_at[c][cc] += 4;
      for (int s = fc + 1; s < d; s++)
        for (int cc = s + 1; cc < MAXC; cc++) stall_at[c][cc]++;
    end
    last_cyc[c] = exp_cyc[c][nins - 1];
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkReset();
    for (int c = 0; c < 2; c++) begin
      checkVal($sformatf("d%0d.rst_rvalid", c), 32'(rv[c]), 32'h0);
      checkVal($sformatf("d%0d.rst_addr", c), addr[c], 32'h0);
      checkVal($sformatf("d%0d.rst_stall", c), 32'(scnt[c]), 32'h0);
      checkVal($sformatf("d%0d.rst_illegal", c), 32'(ill[c]), 32'h0);
      checkVal($sformatf("d%0d.rst_rpc", c), rpc[c], 32'h0);
      checkVal($sformatf("d%0d.rst_rrd", c), 32'(rrd[c]), 32'h0);
      checkVal($sformatf("d%0d.rst_rdata", c), rdata[c], 32'h0);
    end
  endtask

  // Per-cycle comparison of both cores against the reference
  task automatic checkOutput();
    for (int c = 0; c < 2; c++) begin
      checkVal($sformatf("d%0d.addr", c), addr[c], 32'(pc_at[c][cyc]));
      checkVal($sformatf("d%0d.stall", c), 32'(scnt[c]), 32'(stall_at[c][cyc]));
      if (ptr[c] < nins && exp_cyc[c][ptr[c]] == cyc) begin
        checkVal($sformatf("d%0d.rvalid", c), 32'(rv[c]), 32'h1);
        checkVal($sformatf("d%0d.rpc", c), rpc[c], exp_pc[c][ptr[c]]);
        checkVal($sformatf("d%0d.rrd", c), 32'(rrd[c]), 32'(exp_rd[c][ptr[c]]));
        checkVal($sformatf("d%0d.rdata", c), rdata[c], exp_data[c][ptr[c]]);
        checkVal($sformatf("d%0d.illegal", c), 32'(ill[c]), 32'(exp_ill[c][ptr[c]]));
        ptr[c]++;
      end else begin
        checkVal($sformatf("d%0d.rvalid", c), 32'(rv[c]), 32'h0);
        checkVal($sformatf("d%0d.illegal", c), 32'(ill[c]), 32'h0);
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n && i < MAXC; i++) begin
      cyc = i;
      #1;
      checkOutput();
      @(negedge clk);
    end
  endtask

  // Build both models, reset, and run ncyc cycles (or to completion when ncyc < 0)
  task automatic applyStimulus(input string name, input int ncyc);
    int n;
    buildModel(0);
    buildModel(1);
    ptr[0] = 0;
    ptr[1] = 0;
    cyc = 0;
    $display("[TB] scenario %s: %0d instructions", name, nins);
    doReset();
    n = (ncyc >= 0) ? ncyc : ((last_cyc[0] > last_cyc[1] ? last_cyc[0] : last_cyc[1]) + 4);
    runCycles(n);
    if (ncyc < 0) begin
      checkVal("d0.retired", 32'(ptr[0]), 32'(nins));
      checkVal("d1.retired", 32'(ptr[1]), 32'(nins));
    end
  endtask

  task automatic setValidAll();
    for (int i = 0; i < MAXC; i++) vpat[i] = 1'b1;
  endtask

  task automatic loadChain();
    for (int i = 0; i < MAXI; i++) prog[i] = 32'h0;
    prog[0] = enc_i(5, 0, 3'd0, 1);
    prog[1] = enc_i(3, 1, 3'd0, 2);
    prog[2] = enc_i(-10, 2, 3'd0, 3);
    nins = 3;
  endtask

  initial begin
    cyc = 0;
    nins = 1;
    for (int i = 0; i < MAXI; i++) prog[i] = 32'h0;
    setValidAll();

    // Dependent ADDI chain
    loadChain();
    applyStimulus("chain", -1);
    checkVal("d0.chain_stalls", 32'(scnt[0]), 32'd0);
    checkVal("d1.chain_stalls", 32'(scnt[1]), 32'd4);

    // Operation coverage, x0 write, illegal encodings
    prog[0]  = enc_lui(20'h80000, 5);
    prog[1]  = enc_i(32'h404, 5, 3'd5, 6);
    prog[2]  = enc_i(4, 5, 3'd5, 7);
    prog[3]  = enc_i(1, 5, 3'd3, 8);
    prog[4]  = enc_i(0, 5, 3'd2, 9);
    prog[5]  = enc_i(-1, 5, 3'd4, 10);
    prog[6]  = enc_i(7, 0, 3'd0, 0);
    prog[7]  = enc_i(1, 0, 3'd0, 1);
    prog[8]  = 32'h00000033;
    prog[9]  = enc_i(1, 0, 3'd0, 17);
    prog[10] = enc_i(32'h402, 1, 3'd1, 2);
    prog[11] = enc_i(32'h7F0, 10, 3'd6, 3);
    prog[12] = enc_i(32'h0F0, 10, 3'd7, 4);
    prog[13] = enc_i(3, 1, 3'd1, 11);
    prog[14] = enc_i(0, 1, 3'd0, 12);
    nins = 15;
    applyStimulus("ops", -1);

    // Fetch gap of three cycles
    loadChain();
    prog[3] = enc_i(100, 3, 3'd0, 4);
    prog[4] = enc_i(1, 4, 3'd0, 4);
    prog[5] = enc_i(2, 1, 3'd0, 5);
    nins = 6;
    vpat[2] = 1'b0;
    vpat[3] = 1'b0;
    vpat[4] = 1'b0;
    applyStimulus("gap", -1);
    checkVal("d0.gap_stalls", 32'(scnt[0]), 32'd0);
    setValidAll();

    // Randomized programs with hazards and fetch bubbles
    for (int r = 0; r < 6; r++) begin
      nins = 30;
      for (int k = 0; k < nins; k++) begin
        int sel, rd, rs1;
        logic [2:0] f3;
        sel = int'($urandom_range(0, 9));
        rd  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
        rs1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
        f3  = 3'($urandom_range(0, 7));
        if (sel == 0)      prog[k] = enc_lui(int'($urandom), rd);
        else if (sel == 1) prog[k] = ($urandom_range(0, 1) == 0) ? ($urandom | 32'h3) & ~32'h4 | 32'h30
                                                                 : enc_i(32'h200 | int'($urandom_range(0, 31)), rs1, 3'd1, rd);
        else if (f3 == 3'd1 || f3 == 3'd5)
          prog[k] = enc_i((($urandom_range(0, 1) == 0) ? 0 : 32'h400) | int'($urandom_range(0, 31)), rs1, f3, rd);
        else prog[k] = enc_i(int'($urandom), rs1, f3, rd);
      end
      for (int i = 0; i < 250; i++) vpat[i] = ($urandom_range(0, 4) != 0);
      applyStimulus($sformatf("random%0d", r), -1);
      setValidAll();
    end

    // Reset while four instructions are in flight, then re-run the chain
    loadChain();
    prog[3] = enc_i(9, 0, 3'd0, 4);
    prog[4] = enc_i(1, 4, 3'd0, 5);
    prog[5] = enc_i(2, 5, 3'd0, 6);
    nins = 6;
    applyStimulus("inflight", 4);
    cyc = 4;
    #2;
    rst_n = 1'b0;
    #1;
    checkReset();
    loadChain();
    applyStimulus("chain_again", -1);
    checkVal("d0.rerun_stalls", 32'(scnt[0]), 32'd0);
    checkVal("d1.rerun_stalls", 32'(scnt[1]), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
